// File: rtl/pipe_generator_pkg.sv
// Shared flappy-game constants, one-hot state encoding and the gap-draw helper
// used by the pipe generator.
package pipe_generator_pkg;

  localparam int unsigned ScreenW  = 640;
  localparam int unsigned ScreenH  = 480;
  localparam int unsigned PipeW    = 60;
  localparam int unsigned GapH     = 120;
  localparam int unsigned GapMin   = 40;
  localparam int unsigned GapRange = 200;
  localparam int unsigned PipeStep = 2;
  localparam int unsigned ScoreW   = 8;

  localparam logic [7:0] LfsrSeed = 8'hA5;

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StRun  = 3'b010,
    StHold = 3'b100
  } state_e;

  // Folds the 8-bit random value into 0..gap_range and offsets it by gap_min.
  function automatic logic [9:0] gap_top(input logic [7:0] l, input int unsigned gap_min,
                                         input int unsigned gap_range);
    logic [9:0] l_ext;
    logic [9:0] off;
    l_ext = {2'b00, l};
    if (l_ext <= 10'(gap_range)) begin
      off = l_ext;
    end else begin
      off = l_ext - 10'(gap_range) - 10'd1;
    end
    return 10'(gap_min) + off;
  endfunction

endpackage

// File: rtl/pipe_generator_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded on reset so it
// never reaches the all-zero lock-up state.
module lfsr8
  import pipe_generator_pkg::*;
(
  input  logic       Clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] q_d;

  always_comb begin
    q_d = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      q <= LfsrSeed;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/pipe_generator.sv
// Pipe producer: spawns, scrolls and respawns the single visible pipe, draws a
// random gap height and counts pipes cleared by the bird.
module pipe_generator
  import pipe_generator_pkg::*;
#(
  parameter int unsigned SCREEN_W  = ScreenW,
  parameter int unsigned PIPE_W    = PipeW,
  parameter int unsigned STEP      = PipeStep,
  parameter int unsigned GAP_MIN   = GapMin,
  parameter int unsigned GAP_RANGE = GapRange,
  parameter int unsigned GAP_H     = GapH,
  parameter int unsigned SCORE_W   = ScoreW
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               Start,
  input  logic               Tick,
  input  logic               Lose,
  input  logic               Ack,
  input  logic [9:0]         Bird_X_L,
  output logic [9:0]         X_Edge_Left,
  output logic [9:0]         X_Edge_Right,
  output logic [9:0]         Y_Edge_Top,
  output logic [9:0]         Y_Edge_Bottom,
  output logic [SCORE_W-1:0] Score,
  output logic               Pipe_Passed,
  output logic               Q_Idle,
  output logic               Q_Run,
  output logic               Q_Hold
);

  localparam logic [9:0] SpawnLeft  = 10'(SCREEN_W);
  localparam logic [9:0] SpawnRight = 10'(SCREEN_W + PIPE_W);
  localparam logic [9:0] StepPx     = 10'(STEP);
  localparam logic [9:0] GapHPx     = 10'(GAP_H);
  localparam logic [9:0] ResetTop   = 10'(GAP_MIN);

  logic [7:0] lfsr;

  lfsr8 u_lfsr8 (
    .Clk   (Clk),
    .reset (reset),
    .q     (lfsr)
  );

  state_e             state_q, state_d;
  logic [9:0]         x_left_q, x_left_d;
  logic [9:0]         x_right_q, x_right_d;
  logic [9:0]         y_top_q, y_top_d;
  logic [9:0]         y_bot_q, y_bot_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               passed_q, passed_d;
  logic               scored_q, scored_d;
  logic               spawn;
  logic [9:0]         new_top;

  assign new_top = gap_top(lfsr, GAP_MIN, GAP_RANGE);

  always_comb begin
    state_d   = state_q;
    x_left_d  = x_left_q;
    x_right_d = x_right_q;
    y_top_d   = y_top_q;
    y_bot_d   = y_bot_q;
    score_d   = score_q;
    passed_d  = 1'b0;
    scored_d  = scored_q;
    spawn     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StRun;
          score_d = '0;
          spawn   = 1'b1;
        end
      end
      StRun: begin
        if (Lose) begin
          state_d = StHold;
        end else if (Tick) begin
          if (x_left_q < StepPx) begin
            spawn = 1'b1;
          end else begin
            x_left_d  = x_left_q - StepPx;
            x_right_d = x_right_q - StepPx;
            if (!scored_q && (x_right_d < Bird_X_L)) begin
              if (score_q != '1) begin
                score_d = score_q + 1'b1;
              end
              passed_d = 1'b1;
              scored_d = 1'b1;
            end
          end
        end
      end
      StHold: begin
        if (Ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (spawn) begin
      x_left_d  = SpawnLeft;
      x_right_d = SpawnRight;
      y_top_d   = new_top;
      y_bot_d   = new_top + GapHPx;
      scored_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      x_left_q  <= SpawnLeft;
      x_right_q <= SpawnRight;
      y_top_q   <= ResetTop;
      y_bot_q   <= ResetTop + GapHPx;
      score_q   <= '0;
      passed_q  <= 1'b0;
      scored_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_left_q  <= x_left_d;
      x_right_q <= x_right_d;
      y_top_q   <= y_top_d;
      y_bot_q   <= y_bot_d;
      score_q   <= score_d;
      passed_q  <= passed_d;
      scored_q  <= scored_d;
    end
  end

  assign X_Edge_Left   = x_left_q;
  assign X_Edge_Right  = x_right_q;
  assign Y_Edge_Top    = y_top_q;
  assign Y_Edge_Bottom = y_bot_q;
  assign Score         = score_q;
  assign Pipe_Passed   = passed_q;
  assign Q_Idle        = state_q[0];
  assign Q_Run         = state_q[1];
  assign Q_Hold        = state_q[2];

endmodule

// File: tb/tb_pipe_generator.sv
// Directed bench for pipe_generator: full-size instance for geometry, scoring,
// hold and reset; a narrow-screen instance to reach score saturation quickly.
module tb_pipe_generator;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       reset, Start, Tick, Lose, Ack;
  logic [9:0] Bird_X_L;
  logic [9:0] x_l, x_r, y_t, y_b;
  logic [7:0] score;
  logic       pp, q_idle, q_run, q_hold;

  logic       s_start, s_tick;
  logic [9:0] s_x_l, s_x_r, s_y_t, s_y_b;
  logic [7:0] s_score;
  logic       s_pp, s_q_idle, s_q_run, s_q_hold;

  pipe_generator u_dut (
    .Clk           (Clk),
    .reset         (reset),
    .Start         (Start),
    .Tick          (Tick),
    .Lose          (Lose),
    .Ack           (Ack),
    .Bird_X_L      (Bird_X_L),
    .X_Edge_Left   (x_l),
    .X_Edge_Right  (x_r),
    .Y_Edge_Top    (y_t),
    .Y_Edge_Bottom (y_b),
    .Score         (score),
    .Pipe_Passed   (pp),
    .Q_Idle        (q_idle),
    .Q_Run         (q_run),
    .Q_Hold        (q_hold)
  );

  // Narrow screen, 8 px per tick: each pipe lasts 17 ticks and scores on tick 12.
  pipe_generator #(
    .SCREEN_W (128),
    .STEP     (8)
  ) u_small (
    .Clk           (Clk),
    .reset         (reset),
    .Start         (s_start),
    .Tick          (s_tick),
    .Lose          (1'b0),
    .Ack           (1'b0),
    .Bird_X_L      (10'd100),
    .X_Edge_Left   (s_x_l),
    .X_Edge_Right  (s_x_r),
    .Y_Edge_Top    (s_y_t),
    .Y_Edge_Bottom (s_y_b),
    .Score         (s_score),
    .Pipe_Passed   (s_pp),
    .Q_Idle        (s_q_idle),
    .Q_Run         (s_q_run),
    .Q_Hold        (s_q_hold)
  );

  int checks = 0;
  int failures = 0;

  // Reference LFSR advanced alongside the design, used to time Starts and predict gaps.
  logic [7:0] m_lfsr;
  always @(posedge Clk or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic int exp_top(input logic [7:0] l);
    if (int'(l) <= 200) return 40 + int'(l);
    return 40 + int'(l) - 201;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_lfsr(input logic [7:0] target, input string tag);
    int n;
    n = 0;
    while (m_lfsr != target && n < 300) begin
      step();
      n++;
    end
    check(tag, 32'(n < 300), 32'd1);
  endtask

  initial begin
    int         pulses, pulse_tick, n;
    logic [7:0] l_at;

    reset = 1'b1; Start = 1'b0; Tick = 1'b0; Lose = 1'b0; Ack = 1'b0;
    Bird_X_L = 10'd100; s_start = 1'b0; s_tick = 1'b0;
    repeat (3) step();

    check("rst_idle", 32'(q_idle), 32'd1);
    check("rst_run", 32'(q_run), 32'd0);
    check("rst_xl", 32'(x_l), 32'd640);
    check("rst_xr", 32'(x_r), 32'd700);
    check("rst_top", 32'(y_t), 32'd40);
    check("rst_bot", 32'(y_b), 32'd160);
    check("rst_score", 32'(score), 32'd0);
    check("rst_pp", 32'(pp), 32'd0);

    // Start on the first edge after release: lfsr = A5 -> top 205.
    reset = 1'b0;
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("start_run", 32'(q_run), 32'd1);
    check("start_xl", 32'(x_l), 32'd640);
    check("start_xr", 32'(x_r), 32'd700);
    check("start_top", 32'(y_t), 32'd205);
    check("start_bot", 32'(y_b), 32'd325);

    Tick = 1'b1;
    step();
    check("tick1_xl", 32'(x_l), 32'd638);
    check("tick1_xr", 32'(x_r), 32'd698);
    check("tick1_pp", 32'(pp), 32'd0);

    pulses = 0;
    pulse_tick = 0;
    for (int i = 2; i <= 320; i++) begin
      step();
      if (pp) begin
        pulses++;
        pulse_tick = i;
      end
      if (i == 301) begin
        check("t301_xl", 32'(x_l), 32'd38);
        check("t301_xr", 32'(x_r), 32'd98);
        check("t301_score", 32'(score), 32'd1);
      end
    end
    check("pulse_count", 32'(pulses), 32'd1);
    check("pulse_tick", 32'(pulse_tick), 32'd301);
    check("t320_xl", 32'(x_l), 32'd0);
    check("t320_score", 32'(score), 32'd1);

    l_at = m_lfsr;
    step();
    check("respawn_xl", 32'(x_l), 32'd640);
    check("respawn_xr", 32'(x_r), 32'd700);
    check("respawn_top", 32'(y_t), 32'(exp_top(l_at)));
    check("respawn_bot", 32'(y_b), 32'(exp_top(l_at) + 120));
    check("respawn_score", 32'(score), 32'd1);
    check("respawn_pp", 32'(pp), 32'd0);

    // Lose with Tick in the same cycle: hold, no movement.
    Lose = 1'b1;
    step();
    check("lose_hold", 32'(q_hold), 32'd1);
    check("lose_xl", 32'(x_l), 32'd640);
    step();
    check("hold_frozen_xl", 32'(x_l), 32'd640);
    Lose = 1'b0;
    Tick = 1'b0;
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    check("ack_idle", 32'(q_idle), 32'd1);
    check("ack_score_held", 32'(score), 32'd1);

    wait_lfsr(8'hFF, "wait_ff");
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("ff_top", 32'(y_t), 32'd94);
    check("ff_bot", 32'(y_b), 32'd214);
    check("restart_score", 32'(score), 32'd0);
    check("ff_run", 32'(q_run), 32'd1);

    Lose = 1'b1;
    step();
    Lose = 1'b0;
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    wait_lfsr(8'hC8, "wait_c8");
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("c8_top", 32'(y_t), 32'd240);
    check("c8_bot", 32'(y_b), 32'd360);

    Tick = 1'b1;
    n = 0;
    while (score != 8'd3 && n < 1500) begin
      step();
      n++;
    end
    check("reach_score3", 32'(score), 32'd3);

    // Asynchronous reset between edges.
    @(posedge Clk);
    #2 reset = 1'b1;
    #1;
    check("arst_idle", 32'(q_idle), 32'd1);
    check("arst_xl", 32'(x_l), 32'd640);
    check("arst_xr", 32'(x_r), 32'd700);
    check("arst_top", 32'(y_t), 32'd40);
    check("arst_bot", 32'(y_b), 32'd160);
    check("arst_score", 32'(score), 32'd0);
    check("arst_pp", 32'(pp), 32'd0);
    #1 reset = 1'b0;
    Tick = 1'b0;
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("reseed_top", 32'(y_t), 32'd205);

    // Saturation on the narrow instance.
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    s_tick = 1'b1;
    pulses = 0;
    n = 0;
    while (s_score != 8'd255 && n < 4500) begin
      step();
      n++;
      if (s_pp) pulses++;
    end
    check("sat_reach", 32'(s_score), 32'd255);
    check("sat_pulses", 32'(pulses), 32'd255);
    n = 0;
    do begin
      step();
      n++;
    end while (!s_pp && n < 40);
    check("sat_pp", 32'(s_pp), 32'd1);
    check("sat_score", 32'(s_score), 32'd255);
    s_tick = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
